// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master bridge between N_REQ requesters.
// One transfer at a time: IDLE -> ISSUE -> WAIT -> DONE, with an optional hang timeout.
module apb_req_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_write,
    input  logic [N_REQ*9-1:0] req_addr,
    input  logic [N_REQ*8-1:0] req_wdata,
    output logic [N_REQ-1:0]   req_grant,
    output logic [N_REQ-1:0]   req_done,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic               transfer,
    output logic               READ_WRITE,
    output logic [8:0]         apb_write_paddr,
    output logic [7:0]         apb_write_data,
    output logic [8:0]         apb_read_paddr,
    input  logic [7:0]         apb_read_data_out,
    input  logic               PSLVERR,
    input  logic               bus_psel,
    input  logic               PENABLE,
    input  logic               PREADY
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic       write;
        logic [8:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    state_t             state_q, state_d;
    cmd_t               cmd_q;
    logic [PTR_W-1:0]   rr_ptr_q, owner_q;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [N_REQ-1:0]   grant_q, done_q;
    logic [7:0]         rdata_q;
    logic               err_q;
    logic               cpl, timeout_hit, abort;
    int                 sel, arb_idx;

    // Scan from the highest offset down so the first valid at/after rr_ptr wins.
    always_comb begin
        sel     = 0;
        arb_idx = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
            if (req_valid[arb_idx]) sel = arb_idx;
        end
    end

    assign cpl         = bus_psel & PENABLE & PREADY;
    assign cnt_nxt     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_nxt == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            // A bridge left mid-access by an abort must drain before the next issue.
            IDLE:  if (|req_valid && !bus_psel) state_d = ISSUE;
            ISSUE: begin
                if (timeout_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end else if (bus_psel) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cpl) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (state_d == ISSUE) begin
                        grant_q     <= N_REQ'(1) << sel;
                        owner_q     <= PTR_W'(sel);
                        cmd_q.write <= req_write[sel];
                        cmd_q.addr  <= req_addr[sel*9 +: 9];
                        cmd_q.wdata <= req_wdata[sel*8 +: 8];
                    end
                end
                ISSUE, WAIT: begin
                    cnt_q <= cnt_nxt;
                    // Response is captured at the completion edge so DONE is stable.
                    if (state_d == DONE) begin
                        done_q  <= grant_q;
                        rdata_q <= (!abort && !cmd_q.write) ? apb_read_data_out : 8'h00;
                        err_q   <= abort | PSLVERR;
                    end
                end
                DONE: begin
                    grant_q  <= '0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    rr_ptr_q <= (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_grant       = grant_q;
    assign req_done        = done_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign busy            = (state_q != IDLE);
    // Dropped once the bridge shows PSEL so the request is only seen once.
    assign transfer        = (state_q == ISSUE) && !bus_psel;
    assign READ_WRITE      = busy & ~cmd_q.write;
    assign apb_write_paddr = (busy && cmd_q.write)  ? cmd_q.addr  : 9'h000;
    assign apb_write_data  = (busy && cmd_q.write)  ? cmd_q.wdata : 8'h00;
    assign apb_read_paddr  = (busy && !cmd_q.write) ? cmd_q.addr  : 9'h000;

endmodule
